flow_frame_collector: RTL

- Receiving end of the accelerator's streaming flow output.
- Accepts the unthrottled flow_u/flow_v/flow_valid stream and assigns raster coordinates (x, y) to each sample.
- Buffers samples in a small FIFO and re-emits them on a ready/valid output for a downstream writer (DMA or bench file dumper).
- Keeps per-frame statistics: sample count, motion count, overflow.

---
 rtl/flow_frame_collector.sv | 121 ++++++++++++
 1 files changed

// File: rtl/flow_frame_collector.sv
// Tags the incoming flow stream with raster coordinates, buffers it for a ready/valid consumer
// and keeps per-frame sample, motion and overflow statistics.
module flow_frame_collector #(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240,
  parameter int FLOW_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int MOTION_THRESH = 128,
  parameter int CNT_WIDTH     = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  src_done,
  input  logic [FLOW_WIDTH-1:0] flow_u,
  input  logic [FLOW_WIDTH-1:0] flow_v,
  input  logic                  flow_valid,
  output logic [9:0]            out_x,
  output logic [8:0]            out_y,
  output logic [FLOW_WIDTH-1:0] out_u,
  output logic [FLOW_WIDTH-1:0] out_v,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  motion_count,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 10 + 9 + 2 * FLOW_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [9:0]      x;
  logic [8:0]      y;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]     wptr, rptr;
  logic            empty, full, pop, push, last_pos;
  logic [FLOW_WIDTH:0]   u_ext, v_ext, abs_u, abs_v;
  logic [FLOW_WIDTH+1:0] mag;
  logic            is_motion;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = !empty && out_ready;
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign push     = (state == RUN) && flow_valid && (!full || pop);
  assign last_pos = (x == 10'(IMAGE_WIDTH - 1)) && (y == 9'(IMAGE_HEIGHT - 1));

  // One extra bit so the most negative input has a representable magnitude.
  assign u_ext     = {flow_u[FLOW_WIDTH-1], flow_u};
  assign v_ext     = {flow_v[FLOW_WIDTH-1], flow_v};
  assign abs_u     = u_ext[FLOW_WIDTH] ? (~u_ext + 1'b1) : u_ext;
  assign abs_v     = v_ext[FLOW_WIDTH] ? (~v_ext + 1'b1) : v_ext;
  assign mag       = {1'b0, abs_u} + {1'b0, abs_v};
  assign is_motion = (mag >= (FLOW_WIDTH+2)'(MOTION_THRESH));

  assign out_valid = !empty;
  assign busy      = (state != IDLE);
  assign {out_x, out_y, out_u, out_v} = empty ? '0 : mem[rptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if ((flow_valid && last_pos) || src_done) state_nxt = DRAIN;
      DRAIN: begin
        if (empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {x, y, flow_u, flow_v};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      x            <= '0;
      y            <= '0;
      sample_count <= '0;
      motion_count <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (state == IDLE && start) begin
        x            <= '0;
        y            <= '0;
        sample_count <= '0;
        motion_count <= '0;
        overflow     <= 1'b0;
      end
      // Raster position advances on every strobe, dropped or not.
      if (state == RUN && flow_valid) begin
        if (x == 10'(IMAGE_WIDTH - 1)) begin
          x <= '0;
          y <= y + 9'd1;
        end else begin
          x <= x + 10'd1;
        end
        if (!push) overflow <= 1'b1;
      end
      if (push && sample_count != '1) sample_count <= sample_count + 1'b1;
      if (push && is_motion && motion_count != '1) motion_count <= motion_count + 1'b1;
    end
  end

endmodule
